// File: rtl/rvc_fetch_aligner.sv
// Fetch-to-decode instruction aligner: buffers 32-bit fetch words as halfwords and
// presents one 16-bit or 32-bit raw instruction per handshake, with its PC.
module rvc_fetch_aligner #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_word,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            out_is_compressed,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      buf_count
);

    logic [15:0]     buf_q [4];
    logic [15:0]     buf_d [4];
    logic [2:0]      count_q, count_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic            skip_low_q, skip_low_d;

    logic            head_is_c;
    logic            push, pop;
    logic [2:0]      push_n, pop_n, rem;

    // A 32-bit instruction is only offered once both of its halfwords are buffered.
    assign head_is_c = (buf_q[0][1:0] != 2'b11);

    assign in_ready          = (count_q <= 3'd2) && !flush;
    assign out_valid         = !flush && (head_is_c ? (count_q >= 3'd1) : (count_q >= 3'd2));
    assign out_instr         = head_is_c ? {16'h0000, buf_q[0]} : {buf_q[1], buf_q[0]};
    assign out_is_compressed = (count_q != 3'd0) && head_is_c;
    assign out_pc            = head_pc_q;
    assign buf_count         = count_q;

    assign push   = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign push_n = !push ? 3'd0 : (skip_low_q ? 3'd1 : 3'd2);
    assign pop_n  = !pop  ? 3'd0 : (head_is_c  ? 3'd1 : 3'd2);
    assign rem    = count_q - pop_n;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        for (int i = 0; i < 4; i++) buf_d[i] = buf_q[i];
        count_d    = count_q;
        head_pc_d  = head_pc_q;
        skip_low_d = skip_low_q;

        if (flush) begin
            count_d    = 3'd0;
            head_pc_d  = flush_pc;
            skip_low_d = flush_pc[1];
        end else begin
            // Shift out consumed halfwords so the survivors stay in order from index 0.
            if (pop_n == 3'd1) begin
                for (int i = 0; i < 3; i++) buf_d[i] = buf_q[i+1];
            end else if (pop_n == 3'd2) begin
                for (int i = 0; i < 2; i++) buf_d[i] = buf_q[i+2];
            end

            if (push) begin
                for (int i = 0; i < 4; i++) begin
                    if (skip_low_q) begin
                        if (3'(i) == rem) buf_d[i] = in_word[31:16];
                    end else begin
                        if (3'(i) == rem)         buf_d[i] = in_word[15:0];
                        if (3'(i) == rem + 3'd1)  buf_d[i] = in_word[31:16];
                    end
                end
                skip_low_d = 1'b0;
            end

            count_d = rem + push_n;
            if (pop) head_pc_d = head_pc_q + (head_is_c ? XLEN'(2) : XLEN'(4));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= 3'd0;
            head_pc_q  <= RESET_PC;
            skip_low_q <= RESET_PC[1];
            // NOTE: the buffer is cleared too so out_instr reads zero while in reset.
            for (int i = 0; i < 4; i++) buf_q[i] <= 16'h0000;
        end else begin
            // NOTE: state registers use non-blocking assignments only.
            count_q    <= count_d;
            head_pc_q  <= head_pc_d;
            skip_low_q <= skip_low_d;
            for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
        end
    end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Self-checking bench for rvc_fetch_aligner: directed scenarios followed by a
// randomized stream checked against a memory-walking reference model.
module tb_rvc_fetch_aligner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_is_compressed;
    logic [31:0] out_pc;
    logic [2:0]  buf_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [1024];

    rvc_fetch_aligner #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_word           (in_word),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instr         (out_instr),
        .out_is_compressed (out_is_compressed),
        .out_pc            (out_pc),
        .buf_count         (buf_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed no completion, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs are then settled.
    task automatic drive(input logic iv, input logic [31:0] w, input logic ordy,
                         input logic fl, input logic [31:0] fpc);
        @(negedge clk);
        in_valid  = iv;
        in_word   = w;
        out_ready = ordy;
        flush     = fl;
        flush_pc  = fpc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc, input logic c);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".instr"}, out_instr, instr);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".c"}, 32'(out_is_compressed), 32'(c));
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        return mem[a[10:1]];
    endfunction

    logic [31:0] cur_pc, fetch_addr, w, fpc, exp_instr;
    logic [15:0] h0;
    logic        iv, ordy, fl, c_exp, v_exp;
    int          cnt;

    initial begin
        // Reset values while reset is held.
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.pc", out_pc, 32'h0);
        check("rst.instr", out_instr, 32'h0);
        check("rst.c", 32'(out_is_compressed), 32'd0);
        check("rst.count", 32'(buf_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Two compressed instructions from one beat.
        drive(1, 32'h45010505, 1, 0, 0);
        check("t1.in_ready0", 32'(in_ready), 32'd1);
        check("t1.nv", 32'(out_valid), 32'd0);
        drive(0, 0, 1, 0, 0);
        check_out("t1.a", 32'h00000505, 32'h0, 1'b1);
        check("t1.in_ready1", 32'(in_ready), 32'd1);
        drive(0, 0, 1, 0, 0);
        check_out("t1.b", 32'h00004501, 32'h2, 1'b1);
        drive(0, 0, 1, 0, 0);
        check("t1.count", 32'(buf_count), 32'd0);
        check("t1.in_ready2", 32'(in_ready), 32'd1);

        // Straddling 32-bit instruction waits for the next beat.
        do_reset();
        drive(1, 32'h05130505, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        check_out("t2.a", 32'h00000505, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0, 0);
            check("t2.gap", 32'(out_valid), 32'd0);
            check("t2.gapcnt", 32'(buf_count), 32'd1);
        end
        drive(1, 32'h45010000, 1, 0, 0);
        check("t2.gap3", 32'(out_valid), 32'd0);
        drive(0, 0, 1, 0, 0);
        check_out("t2.b", 32'h00000513, 32'h2, 1'b0);
        drive(0, 0, 1, 0, 0);
        check_out("t2.c", 32'h00004501, 32'h6, 1'b1);

        // Backpressure: buffer fills to four halfwords, third beat stalls.
        do_reset();
        drive(1, 32'h00000013, 0, 0, 0);
        check("t3.rdy1", 32'(in_ready), 32'd1);
        drive(1, 32'h00000013, 0, 0, 0);
        check("t3.rdy2", 32'(in_ready), 32'd1);
        check_out("t3.hold0", 32'h00000013, 32'h0, 1'b0);
        drive(1, 32'h00000013, 0, 0, 0);
        check("t3.rdy3", 32'(in_ready), 32'd0);
        check("t3.full", 32'(buf_count), 32'd4);
        check_out("t3.hold1", 32'h00000013, 32'h0, 1'b0);
        drive(1, 32'h00000013, 1, 0, 0);
        check("t3.rdy4", 32'(in_ready), 32'd0);
        check_out("t3.a", 32'h00000013, 32'h0, 1'b0);
        drive(1, 32'h00000013, 1, 0, 0);
        check("t3.rdy5", 32'(in_ready), 32'd1);
        check_out("t3.b", 32'h00000013, 32'h4, 1'b0);
        drive(0, 0, 1, 0, 0);
        check_out("t3.c", 32'h00000013, 32'h8, 1'b0);
        drive(0, 0, 1, 0, 0);
        check("t3.empty", 32'(buf_count), 32'd0);

        // Simultaneous push and pop.
        do_reset();
        drive(1, 32'h45010505, 0, 0, 0);
        drive(1, 32'h00000013, 1, 0, 0);
        check("t5.cnt2", 32'(buf_count), 32'd2);
        check_out("t5.a", 32'h00000505, 32'h0, 1'b1);
        drive(0, 0, 1, 0, 0);
        check("t5.cnt3", 32'(buf_count), 32'd3);
        check_out("t5.b", 32'h00004501, 32'h2, 1'b1);
        drive(0, 0, 1, 0, 0);
        check_out("t5.c", 32'h00000013, 32'h4, 1'b0);
        drive(0, 0, 1, 0, 0);
        check("t5.empty", 32'(buf_count), 32'd0);

        // Flush to a halfword-aligned target with three halfwords buffered.
        do_reset();
        drive(1, 32'h45010505, 0, 0, 0);
        drive(1, 32'h00000013, 1, 0, 0);
        drive(1, 32'hdeadbeef, 1, 1, 32'h102);
        check("t4.fl_rdy", 32'(in_ready), 32'd0);
        check("t4.fl_vld", 32'(out_valid), 32'd0);
        drive(1, 32'h45010505, 1, 0, 0);
        check("t4.cnt0", 32'(buf_count), 32'd0);
        check("t4.nv", 32'(out_valid), 32'd0);
        check("t4.pc", out_pc, 32'h102);
        drive(1, 32'h00000013, 1, 0, 0);
        check("t4.cnt1", 32'(buf_count), 32'd1);
        check_out("t4.a", 32'h00004501, 32'h102, 1'b1);
        drive(0, 0, 1, 0, 0);
        check_out("t4.b", 32'h00000013, 32'h104, 1'b0);
        drive(0, 0, 1, 0, 0);
        check("t4.empty", 32'(buf_count), 32'd0);

        // Asynchronous reset in the middle of a cycle.
        do_reset();
        drive(1, 32'h45010505, 0, 0, 0);
        drive(1, 32'h00000013, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t6.pre", 32'(buf_count), 32'd3);
        #1 reset_n = 1'b0;
        #1;
        check("t6.vld", 32'(out_valid), 32'd0);
        check("t6.cnt", 32'(buf_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("t6.pc", out_pc, 32'h0);

        // Randomized stream: the model walks a halfword memory image from the current PC.
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(0, 1) == 1) mem[i][1:0] = 2'b11;
        end
        do_reset();
        cur_pc = 32'h0;
        fetch_addr = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            fl   = ($urandom_range(0, 39) == 0);
            fpc  = 32'($urandom_range(0, 1023)) << 1;
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            w    = {hw_at(fetch_addr + 32'd2), hw_at(fetch_addr)};
            drive(iv, w, ordy, fl, fpc);

            cnt = (int'(fetch_addr) - int'(cur_pc)) / 2;
            if (cnt < 0) cnt = 0;
            h0 = hw_at(cur_pc);
            c_exp = (h0[1:0] != 2'b11);
            exp_instr = c_exp ? {16'h0, h0} : {hw_at(cur_pc + 32'd2), h0};
            v_exp = !fl && (cnt >= 1) && (c_exp || cnt >= 2);

            check("rnd.count", 32'(buf_count), 32'(cnt));
            check("rnd.in_ready", 32'(in_ready), 32'(!fl && cnt <= 2));
            check("rnd.valid", 32'(out_valid), 32'(v_exp));
            check("rnd.pc", out_pc, cur_pc);
            if (v_exp) begin
                check("rnd.instr", out_instr, exp_instr);
                check("rnd.c", 32'(out_is_compressed), 32'(c_exp));
            end

            if (fl) begin
                cur_pc = fpc;
                fetch_addr = {fpc[31:2], 2'b00};
            end else begin
                if (v_exp && ordy) cur_pc = cur_pc + (c_exp ? 32'd2 : 32'd4);
                if (iv && cnt <= 2) fetch_addr = fetch_addr + 32'd4;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
